// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out word serializer with valid/ready load and per-word bit order.
// Latency: word accepted at edge E drives bit i in cycle E+1+i; done pulses in cycle E+WIDTH+1.
// Backpressure: load_ready only in IDLE or on the last-bit cycle; enable=0 freezes all state.
module piso_stream_serializer #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data,
  input  logic             msb_first,
  input  logic             serial_in,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             dir;
  logic             done_q;
  logic             last_bit;
  logic             accept;

  // State register; reset wins over enable, enable=0 freezes the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake and output decode from registered state.
  always_comb begin
    state_nxt  = state;
    last_bit   = (state == SHIFT) && (cnt == '0);
    load_ready = enable & ~reset & ((state == IDLE) | last_bit);
    accept     = load_valid & load_ready;
    out        = IDLE_LEVEL;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out       = dir ? sreg[WIDTH-1] : sreg[0];
        // A reload on the last-bit edge keeps us in SHIFT for gapless streaming.
        if (last_bit && !accept) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on handshake, otherwise shift toward the output end with fill at the far end.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg   <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      done_q <= 1'b0;
    end else if (enable) begin
      done_q <= last_bit;
      if (accept) begin
        sreg <= data;
        dir  <= msb_first;
        cnt  <= CNT_LOAD;
      end else if (state == SHIFT) begin
        if (dir) begin
          sreg <= {sreg[WIDTH-2:0], serial_in};
        end else begin
          sreg <= {serial_in, sreg[WIDTH-1:1]};
        end
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
      end
    end else begin
      // A stalled completion edge is not a completion; the pulse comes on the enabled edge.
      done_q <= 1'b0;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Directed bench for piso_stream_serializer: WIDTH=4 and WIDTH=8 instances.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-derived bit sequences.
module tb_piso_stream_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load_valid;
  logic       msb_first;
  logic       serial_in;
  logic [3:0] data4;
  logic [7:0] data8;

  logic load_ready4, out4, out_valid4, busy4, done4;
  logic load_ready8, out8, out_valid8, busy8, done8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_stream_serializer #(.WIDTH(4), .IDLE_LEVEL(1'b0)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(load_ready4), .data(data4), .msb_first(msb_first),
    .serial_in(serial_in), .out(out4), .out_valid(out_valid4),
    .busy(busy4), .done(done4)
  );

  piso_stream_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(load_ready8), .data(data8), .msb_first(msb_first),
    .serial_in(serial_in), .out(out8), .out_valid(out_valid8),
    .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word to the WIDTH=4 instance for exactly one edge.
  task automatic load4(input logic [3:0] d, input logic msb);
    data4      = d;
    msb_first  = msb;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  // Check four serial bits (first bit in exp[0]) then the done cycle.
  task automatic expect4(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_out"}, 8'(out4), 8'(exp[i]));
      chk({tag, "_vld"}, 8'(out_valid4), 8'h1);
      chk({tag, "_busy"}, 8'(busy4), 8'h1);
      chk({tag, "_done0"}, 8'(done4), 8'h0);
      tick();
    end
    chk({tag, "_done"}, 8'(done4), 8'h1);
    chk({tag, "_idle_out"}, 8'(out4), 8'h0);
    chk({tag, "_idle_vld"}, 8'(out_valid4), 8'h0);
    chk({tag, "_idle_busy"}, 8'(busy4), 8'h0);
    chk({tag, "_ready"}, 8'(load_ready4), 8'h1);
    tick();
    chk({tag, "_done_end"}, 8'(done4), 8'h0);
  endtask

  initial begin
    logic [7:0] seq8;
    logic [7:0] exp8;
    reset      = 1'b1;
    enable     = 1'b1;
    load_valid = 1'b0;
    msb_first  = 1'b0;
    serial_in  = 1'b1;
    data4      = '0;
    data8      = '0;

    // Reset state
    tick();
    chk("rst_out", 8'(out4), 8'h0);
    chk("rst_vld", 8'(out_valid4), 8'h0);
    chk("rst_busy", 8'(busy4), 8'h0);
    chk("rst_done", 8'(done4), 8'h0);
    chk("rst_ready", 8'(load_ready4), 8'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 8'(load_ready4), 8'h1);

    // MSB-first 1011 -> 1,0,1,1 (first bit in bit 0 of the vector)
    load4(4'b1011, 1'b1);
    expect4("msb", 4'b1101);

    // LSB-first 0011 -> 1,1,0,0
    load4(4'b0011, 1'b0);
    expect4("lsb", 4'b0011);

    // Back-to-back: 1010 MSB-first with load_valid held, then 0111 LSB-first on the last-bit cycle
    data4      = 4'b1010;
    msb_first  = 1'b1;
    load_valid = 1'b1;
    tick();
    seq8 = 8'b0111_0101; // stream 1,0,1,0,1,1,1,0 read from bit 0 upward
    for (int i = 0; i < 8; i++) begin
      chk("b2b_out", 8'(out4), 8'(seq8[i]));
      chk("b2b_vld", 8'(out_valid4), 8'h1);
      chk("b2b_done", 8'(done4), (i == 4) ? 8'h1 : 8'h0);
      if (i < 3) chk("b2b_ready_busy", 8'(load_ready4), 8'h0);
      if (i == 3) begin
        chk("b2b_ready_last", 8'(load_ready4), 8'h1);
        data4     = 4'b0111;
        msb_first = 1'b0;
      end
      tick();
      if (i == 3) load_valid = 1'b0;
    end
    chk("b2b_done2", 8'(done4), 8'h1);
    chk("b2b_idle_vld", 8'(out_valid4), 8'h0);
    tick();

    // Enable stall: 1000 MSB-first, 3 frozen cycles after bit 1
    load4(4'b1000, 1'b1);
    chk("stall_b0", 8'(out4), 8'h1);
    enable = 1'b0;
    #1;
    chk("stall_ready", 8'(load_ready4), 8'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_out", 8'(out4), 8'h1);
      chk("stall_hold_vld", 8'(out_valid4), 8'h1);
      chk("stall_hold_done", 8'(done4), 8'h0);
    end
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_rest", 8'(out4), 8'h0);
      chk("stall_rest_done", 8'(done4), 8'h0);
      tick();
    end
    chk("stall_done", 8'(done4), 8'h1);
    tick();

    // A word presented while enable=0 is ignored
    enable = 1'b0;
    load4(4'b1111, 1'b1);
    enable = 1'b1;
    tick();
    chk("dis_noload_vld", 8'(out_valid4), 8'h0);
    chk("dis_noload_busy", 8'(busy4), 8'h0);

    // Mid-word reset after bit 2 of 1111
    load4(4'b1111, 1'b1);
    chk("mrst_b0", 8'(out4), 8'h1);
    tick();
    chk("mrst_b1", 8'(out4), 8'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_out", 8'(out4), 8'h0);
    chk("mrst_vld", 8'(out_valid4), 8'h0);
    chk("mrst_busy", 8'(busy4), 8'h0);
    chk("mrst_done", 8'(done4), 8'h0);
    tick();
    chk("mrst_nodone", 8'(done4), 8'h0);
    load4(4'b0110, 1'b1);
    expect4("mrst_reload", 4'b0110);

    // WIDTH=8, A5 MSB-first with serial_in=1 fill
    reset = 1'b1;
    tick();
    reset = 1'b0;
    serial_in  = 1'b1;
    data8      = 8'hA5;
    msb_first  = 1'b1;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    exp8 = 8'b1010_0101; // emitted MSB first
    for (int i = 0; i < 8; i++) begin
      chk("w8_out", 8'(out8), 8'(exp8[7-i]));
      chk("w8_vld", 8'(out_valid8), 8'h1);
      chk("w8_done0", 8'(done8), 8'h0);
      tick();
    end
    chk("w8_done", 8'(done8), 8'h1);
    chk("w8_idle_out", 8'(out8), 8'h0);
    chk("w8_idle_vld", 8'(out_valid8), 8'h0);
    tick();
    chk("w8_after_out", 8'(out8), 8'h0);
    chk("w8_after_done", 8'(done8), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
